id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- ID/EX pipeline register of the five-stage core, sitting directly upstream of the ALU.
- Latches decoded operands and control from ID, then resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Drives the ALU operand and control inputs, and passes MEM/WB control downstream.
- Flags load-use hazards so the hazard unit can stall ID.

Parameters:
- REG_ADDR_W, 5, register-index width.
- RESET_PC_NOP, 1, when 1 a reset or flush loads a NOP: all control 0, alu_ctrl = `ADD.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- stall_i  in  1  hold the ID/EX contents.
- flush_i  in  1  insert a bubble; wins over stall_i.
- id_valid  in  1  ID holds a real instruction.
- id_rs1_addr, id_rs2_addr, id_rd_addr  in  REG_ADDR_W  register indices.
- id_rs1_data, id_rs2_data, id_imm  in  `CPU_WIDTH  register-file reads and sign-extended immediate.
- id_alu_src  in  1  0 = rs2 feeds ALU input 2, 1 = immediate feeds it.
- id_alu_ctrl  in  `ALU_CTRL_WIDTH  ALU opcode.
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch  in  1  control bits.
- exmem_reg_write  in  1  EX/MEM writeback enable.
- exmem_rd_addr  in  REG_ADDR_W  EX/MEM destination index.
- exmem_alu_result  in  `CPU_WIDTH  EX/MEM result.
- memwb_reg_write  in  1  MEM/WB writeback enable.
- memwb_rd_addr  in  REG_ADDR_W  MEM/WB destination index.
- memwb_wb_data  in  `CPU_WIDTH  MEM/WB writeback data.
- alu_data_in_1, alu_data_in_2  out  `CPU_WIDTH  ALU operands.
- alu_ctrl  out  `ALU_CTRL_WIDTH  ALU opcode.
- ex_store_data  out  `CPU_WIDTH  forwarded rs2 value, used for stores.
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch  out  1  registered control.
- ex_rd_addr  out  REG_ADDR_W  registered destination index.
- fwd_a_sel, fwd_b_sel  out  2  forwarding select: 0 = register, 1 = MEM/WB, 2 = EX/MEM.
- load_use_hazard  out  1  combinational hazard flag.

Behaviour:
- Reset (async, rst_n = 0): every register, including the stored rs1/rs2 data, is cleared to 0.
  - ex_valid = 0, all control outputs = 0, alu_ctrl = `ADD, fwd selects = 0.
  - Operand outputs are then 0, with imm = 0.
- Priority on each rising edge: flush_i > stall_i > load.
  - flush_i: load a NOP (as at reset; rs data is don't-care and is zeroed).
  - stall_i: hold all registers, except that the stored rs1/rs2 data is overwritten with the currently forwarded values. This keeps a forwarding source that retires during the stall from being lost.
  - Otherwise: capture all id_* inputs; ex_valid <= id_valid.
- Any control bit captured while id_valid = 0 is forced to 0.
- Latency: one cycle from ID to the ALU inputs. All forwarding and operand muxing is combinational from the registered state.
- Forwarding rule for source X in {rs1, rs2}:
  - EX/MEM match if exmem_reg_write, exmem_rd_addr != 0 and exmem_rd_addr == X. This case selects 2.
  - Otherwise MEM/WB match under the same conditions, which selects 1.
  - Otherwise 0.
  - EX/MEM always wins when both stages match.
  - An address of x0 is never forwarded.
- alu_data_in_1 = forwarded rs1.
- alu_data_in_2 = registered imm if alu_src = 1, else forwarded rs2.
- ex_store_data = forwarded rs2, regardless of alu_src.
- load_use_hazard = ex_valid & ex_mem_read & ex_rd_addr != 0 & (ex_rd_addr == id_rs1_addr | ex_rd_addr == id_rs2_addr).
  - Computed combinationally and not masked by stall_i.
  - The hazard unit responds by asserting stall on PC/IF-ID and flush_i here.
- Reset mid-stall: reset dominates; the bench must see a NOP on the next deassertion edge.

Optional Feature:
- Macro: ID_EX_FWD_EN.
- Defined: forwarding exactly as above.
- Undefined:
  - fwd_a_sel and fwd_b_sel are tied to 0.
  - Operands come straight from the stored register data.
  - The stall refresh stores the raw data.
  - load_use_hazard widens to any ex_reg_write match (ex_valid & ex_reg_write & ex_rd_addr != 0 & match), so software-visible correctness relies on stalls.

Decomposition:
- Shared package/include (riscv_define) holds `CPU_WIDTH, `ALU_CTRL_WIDTH, the ALU opcodes and the forwarding-select constants FWD_REG=0, FWD_WB=1, FWD_MEM=2.
- One sub-module is natural: fwd_unit, purely combinational. It takes the rs addresses plus the EX/MEM and MEM/WB writeback info and produces the two selects. It is instantiated once for both sources.

Test Plan:
- Reset with rst_n = 0 mid-cycle -> outputs clear immediately: ex_valid = 0, alu_ctrl = `ADD, operands = 0.
- Load rs1 = 3, rs2 = 4, data 0x10 and 0x20, alu_src = 0, no forwarding -> next cycle alu_data_in_1 = 0x10, alu_data_in_2 = 0x20, fwd selects = 0.
- Double match: EX/MEM rd = 3 with result 0xAA and MEM/WB rd = 3 with data 0xBB -> alu_data_in_1 = 0xAA, fwd_a_sel = 2. Repeat with exmem_reg_write = 0 -> 0xBB, sel = 1. Repeat with rd = 0 -> register value.
- Stall refresh: stall_i = 1 while MEM/WB forwards 0x55 to rs2, then the MEM/WB match is removed while still stalled -> alu_data_in_2 stays 0x55.
- Stored ex_mem_read = 1, ex_rd_addr = 5, id_rs2_addr = 5 -> load_use_hazard = 1. Then flush_i = 1 together with stall_i = 1 -> NOP loaded, ex_valid = 0.
- id_alu_src = 1, imm = 0xFFFF_FFFC, with rs2 forwarding active -> alu_data_in_2 = 0xFFFF_FFFC and ex_store_data = the forwarded rs2 value.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared widths, ALU opcodes and forwarding-select codes for the ID/EX stage.
// Forwarding itself is enabled by defining ID_EX_FWD_EN.
package id_ex_stage_pkg;

   localparam int CPU_WIDTH      = 32;
   localparam int ALU_CTRL_WIDTH = 4;

   typedef enum logic [ALU_CTRL_WIDTH-1:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLL  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9
   } alu_op_e;

   localparam logic [1:0] FWD_REG = 2'd0;
   localparam logic [1:0] FWD_WB  = 2'd1;
   localparam logic [1:0] FWD_MEM = 2'd2;

   typedef struct packed {
      logic valid;
      logic reg_write;
      logic mem_read;
      logic mem_write;
      logic mem_to_reg;
      logic branch;
      logic alu_src;
   } ex_ctrl_t;

   function automatic logic [CPU_WIDTH-1:0] fwd_mux(
      input logic [1:0]           sel,
      input logic [CPU_WIDTH-1:0] reg_val,
      input logic [CPU_WIDTH-1:0] wb_val,
      input logic [CPU_WIDTH-1:0] mem_val
   );
      case (sel)
         FWD_MEM: fwd_mux = mem_val;
         FWD_WB:  fwd_mux = wb_val;
         default: fwd_mux = reg_val;
      endcase
   endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX bundle: decoded ID inputs, writeback bypass info and the EX-side outputs.
// master drives ID/bypass and observes EX; slave is the pipeline register.
interface id_ex_stage_if #(
   parameter int REG_ADDR_W = 5
);
   import id_ex_stage_pkg::*;

   logic                      id_valid;
   logic [REG_ADDR_W-1:0]     id_rs1_addr, id_rs2_addr, id_rd_addr;
   logic [CPU_WIDTH-1:0]      id_rs1_data, id_rs2_data, id_imm;
   logic                      id_alu_src;
   logic [ALU_CTRL_WIDTH-1:0] id_alu_ctrl;
   logic                      id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch;

   logic                      exmem_reg_write;
   logic [REG_ADDR_W-1:0]     exmem_rd_addr;
   logic [CPU_WIDTH-1:0]      exmem_alu_result;
   logic                      memwb_reg_write;
   logic [REG_ADDR_W-1:0]     memwb_rd_addr;
   logic [CPU_WIDTH-1:0]      memwb_wb_data;

   logic [CPU_WIDTH-1:0]      alu_data_in_1, alu_data_in_2, ex_store_data;
   logic [ALU_CTRL_WIDTH-1:0] alu_ctrl;
   logic                      ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch;
   logic [REG_ADDR_W-1:0]     ex_rd_addr;
   logic [1:0]                fwd_a_sel, fwd_b_sel;
   logic                      load_use_hazard;

   modport master (
      output id_valid, id_rs1_addr, id_rs2_addr, id_rd_addr, id_rs1_data, id_rs2_data, id_imm,
             id_alu_src, id_alu_ctrl, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
             id_branch, exmem_reg_write, exmem_rd_addr, exmem_alu_result,
             memwb_reg_write, memwb_rd_addr, memwb_wb_data,
      input  alu_data_in_1, alu_data_in_2, ex_store_data, alu_ctrl, ex_valid, ex_reg_write,
             ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch, ex_rd_addr,
             fwd_a_sel, fwd_b_sel, load_use_hazard
   );

   modport slave (
      input  id_valid, id_rs1_addr, id_rs2_addr, id_rd_addr, id_rs1_data, id_rs2_data, id_imm,
             id_alu_src, id_alu_ctrl, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
             id_branch, exmem_reg_write, exmem_rd_addr, exmem_alu_result,
             memwb_reg_write, memwb_rd_addr, memwb_wb_data,
      output alu_data_in_1, alu_data_in_2, ex_store_data, alu_ctrl, ex_valid, ex_reg_write,
             ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch, ex_rd_addr,
             fwd_a_sel, fwd_b_sel, load_use_hazard
   );

endinterface

// File: rtl/id_ex_stage_fwd_unit.sv
// Combinational forwarding select for rs1 (a) and rs2 (b); EX/MEM beats MEM/WB, x0 never forwards.
module id_ex_stage_fwd_unit
   import id_ex_stage_pkg::*;
#(
   parameter int REG_ADDR_W = 5
) (
   input  logic [REG_ADDR_W-1:0] rs1_addr,
   input  logic [REG_ADDR_W-1:0] rs2_addr,
   input  logic                  exmem_reg_write,
   input  logic [REG_ADDR_W-1:0] exmem_rd_addr,
   input  logic                  memwb_reg_write,
   input  logic [REG_ADDR_W-1:0] memwb_rd_addr,
   output logic [1:0]            fwd_a_sel,
   output logic [1:0]            fwd_b_sel
);

   logic [1:0][REG_ADDR_W-1:0] src_addr;
   logic [1:0][1:0]            src_sel;

   assign src_addr[0] = rs1_addr;
   assign src_addr[1] = rs2_addr;

   for (genvar gi = 0; gi < 2; gi++) begin : g_src
      logic exmem_hit;
      logic memwb_hit;
      assign exmem_hit = exmem_reg_write && (exmem_rd_addr != '0) && (exmem_rd_addr == src_addr[gi]);
      assign memwb_hit = memwb_reg_write && (memwb_rd_addr != '0) && (memwb_rd_addr == src_addr[gi]);
      assign src_sel[gi] = exmem_hit ? FWD_MEM : (memwb_hit ? FWD_WB : FWD_REG);
   end

   assign fwd_a_sel = src_sel[0];
   assign fwd_b_sel = src_sel[1];

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use detection.
// Define ID_EX_FWD_EN to enable EX/MEM and MEM/WB bypassing; otherwise hazards rely on stalls.
module id_ex_stage
   import id_ex_stage_pkg::*;
#(
   parameter int REG_ADDR_W   = 5,
   parameter bit RESET_PC_NOP = 1'b1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         stall_i,
   input  logic         flush_i,
   id_ex_stage_if.slave bus
);

   ex_ctrl_t                  ctrl_q, ctrl_d;
   logic [ALU_CTRL_WIDTH-1:0] alu_ctrl_q, alu_ctrl_d;
   logic [REG_ADDR_W-1:0]     rs1_addr_q, rs1_addr_d, rs2_addr_q, rs2_addr_d, rd_addr_q, rd_addr_d;
   logic [CPU_WIDTH-1:0]      rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d, imm_q, imm_d;

   logic [1:0]                raw_a_sel, raw_b_sel, sel_a, sel_b;
   logic [CPU_WIDTH-1:0]      fwd_rs1, fwd_rs2;
   logic                      hazard_src;

   id_ex_stage_fwd_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd (
      .rs1_addr        (rs1_addr_q),
      .rs2_addr        (rs2_addr_q),
      .exmem_reg_write (bus.exmem_reg_write),
      .exmem_rd_addr   (bus.exmem_rd_addr),
      .memwb_reg_write (bus.memwb_reg_write),
      .memwb_rd_addr   (bus.memwb_rd_addr),
      .fwd_a_sel       (raw_a_sel),
      .fwd_b_sel       (raw_b_sel)
   );

`ifdef ID_EX_FWD_EN
   assign sel_a      = raw_a_sel;
   assign sel_b      = raw_b_sel;
   assign hazard_src = ctrl_q.mem_read;
`else
   // Without bypassing any in-flight writer of a source register must stall ID.
   logic unused_fwd_sel;
   assign unused_fwd_sel = ^{raw_a_sel, raw_b_sel};
   assign sel_a          = FWD_REG;
   assign sel_b          = FWD_REG;
   assign hazard_src     = ctrl_q.reg_write;
`endif

   assign fwd_rs1 = fwd_mux(sel_a, rs1_data_q, bus.memwb_wb_data, bus.exmem_alu_result);
   assign fwd_rs2 = fwd_mux(sel_b, rs2_data_q, bus.memwb_wb_data, bus.exmem_alu_result);

   always_comb begin
      ctrl_d     = ctrl_q;
      alu_ctrl_d = alu_ctrl_q;
      rs1_addr_d = rs1_addr_q;
      rs2_addr_d = rs2_addr_q;
      rd_addr_d  = rd_addr_q;
      rs1_data_d = rs1_data_q;
      rs2_data_d = rs2_data_q;
      imm_d      = imm_q;
      if (flush_i) begin
         ctrl_d = '0;
         if (RESET_PC_NOP) begin
            alu_ctrl_d = ALU_ADD;
            rs1_addr_d = '0;
            rs2_addr_d = '0;
            rd_addr_d  = '0;
            rs1_data_d = '0;
            rs2_data_d = '0;
            imm_d      = '0;
         end
      end else if (stall_i) begin
         // Capture the bypassed value so a source retiring mid-stall is not lost.
         rs1_data_d = fwd_rs1;
         rs2_data_d = fwd_rs2;
      end else begin
         ctrl_d.valid      = bus.id_valid;
         ctrl_d.reg_write  = bus.id_valid & bus.id_reg_write;
         ctrl_d.mem_read   = bus.id_valid & bus.id_mem_read;
         ctrl_d.mem_write  = bus.id_valid & bus.id_mem_write;
         ctrl_d.mem_to_reg = bus.id_valid & bus.id_mem_to_reg;
         ctrl_d.branch     = bus.id_valid & bus.id_branch;
         ctrl_d.alu_src    = bus.id_valid & bus.id_alu_src;
         alu_ctrl_d        = bus.id_alu_ctrl;
         rs1_addr_d        = bus.id_rs1_addr;
         rs2_addr_d        = bus.id_rs2_addr;
         rd_addr_d         = bus.id_rd_addr;
         rs1_data_d        = bus.id_rs1_data;
         rs2_data_d        = bus.id_rs2_data;
         imm_d             = bus.id_imm;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_q     <= '0;
         alu_ctrl_q <= ALU_ADD;
         rs1_addr_q <= '0;
         rs2_addr_q <= '0;
         rd_addr_q  <= '0;
         rs1_data_q <= '0;
         rs2_data_q <= '0;
         imm_q      <= '0;
      end else begin
         ctrl_q     <= ctrl_d;
         alu_ctrl_q <= alu_ctrl_d;
         rs1_addr_q <= rs1_addr_d;
         rs2_addr_q <= rs2_addr_d;
         rd_addr_q  <= rd_addr_d;
         rs1_data_q <= rs1_data_d;
         rs2_data_q <= rs2_data_d;
         imm_q      <= imm_d;
      end
   end

   assign bus.alu_data_in_1   = fwd_rs1;
   assign bus.alu_data_in_2   = ctrl_q.alu_src ? imm_q : fwd_rs2;
   assign bus.ex_store_data   = fwd_rs2;
   assign bus.alu_ctrl        = alu_ctrl_q;
   assign bus.ex_valid        = ctrl_q.valid;
   assign bus.ex_reg_write    = ctrl_q.reg_write;
   assign bus.ex_mem_read     = ctrl_q.mem_read;
   assign bus.ex_mem_write    = ctrl_q.mem_write;
   assign bus.ex_mem_to_reg   = ctrl_q.mem_to_reg;
   assign bus.ex_branch       = ctrl_q.branch;
   assign bus.ex_rd_addr      = rd_addr_q;
   assign bus.fwd_a_sel       = sel_a;
   assign bus.fwd_b_sel       = sel_b;
   assign bus.load_use_hazard = ctrl_q.valid & hazard_src & (rd_addr_q != '0) &
                                ((rd_addr_q == bus.id_rs1_addr) | (rd_addr_q == bus.id_rs2_addr));

endmodule
